// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN frame sequencer:
//   - seq_state_e : sequencer FSM states
//   - ERR_*       : result error codes reported on res_err
//   - ERR_CLASS   : class value reported when a frame ends in error
//   - IMG_PIXELS_DEF / PIX_CNT_W : default frame size and pixel counter width
//   - max_int     : helper for sizing the shared timer
// ---------------------------------------------------------------------------
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } seq_state_e;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_UNDERRUN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    localparam logic [3:0] ERR_CLASS = 4'hF;

    localparam int IMG_PIXELS_DEF = 784;
    localparam int PIX_CNT_W      = 11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_seq_timer.sv
// ---------------------------------------------------------------------------
// cnn_seq_timer
// Loadable up-counter with a terminal-count flag. One instance is shared by
// the sequencer for the flush length, the pixel count and the decision
// timeout; the sequencer selects the terminal value per state.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (count -> 0)
//   load_i     in   load load_val_i (has priority over inc_i)
//   load_val_i in   value to load
//   inc_i      in   increment by one
//   term_val_i in   terminal value to compare against
//   term_o     out  count equals term_val_i (combinational on the count)
// ---------------------------------------------------------------------------
module cnn_seq_timer
    import cnn_pkg::*;
#(
    parameter int WIDTH = PIX_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] term_val_i,
    output logic             term_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/cnn_frame_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_frame_sequencer
// Sequences one image frame into a CNN datapath: resets the datapath, streams
// IMG_PIXELS host pixels into it, waits for the decision and holds the result
// until the host consumes it. All outputs are registered.
//
// Parameters:
//   IMG_PIXELS  pixels per frame
//   FLUSH_CYC   datapath reset cycles before streaming (>= 1)
//   TIMEOUT_CYC max WAIT cycles before a timeout result
//
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   start                    frame request (only honoured in IDLE)
//   pix_valid, pix_data      host pixel stream
//   pix_ready                sequencer accepts a pixel this cycle
//   cnn_rst_n                active-low datapath reset
//   cnn_data_out             pixel to datapath, one cycle after accept
//   cnn_valid, cnn_decision  datapath decision (only sampled in WAIT)
//   res_valid, res_class,
//   res_err, res_ready       result handshake to host
//   busy                     sequencer not idle
//   lat_cycles               (CNN_SEQ_PERF_EN only) cycles from first accept
//                            to RESULT entry, saturating, valid with res_valid
//
// Optional build macro: CNN_SEQ_PERF_EN adds the lat_cycles output.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | parked, datapath held in reset, waiting for start
// ST_FLUSH  | datapath reset for FLUSH_CYC cycles
// ST_STREAM | accepting pixels; datapath released on first accept
// ST_WAIT   | all pixels sent, waiting for decision or timeout
// ST_RESULT | result presented until host handshake
// ---------------------------------------------------------------------------
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int IMG_PIXELS  = IMG_PIXELS_DEF,
    parameter int FLUSH_CYC   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       cnn_rst_n,
    output logic [7:0] cnn_data_out,
    input  logic       cnn_valid,
    input  logic [3:0] cnn_decision,
    output logic       res_valid,
    output logic [3:0] res_class,
    output logic [1:0] res_err,
    input  logic       res_ready,
    output logic       busy
`ifdef CNN_SEQ_PERF_EN
    ,
    output logic [15:0] lat_cycles
`endif
);

    // Shared timer must hold the largest of the three terminal values.
    localparam int TMR_W = max_int(PIX_CNT_W,
                                   max_int($clog2(TIMEOUT_CYC), $clog2(FLUSH_CYC + 1)));

    localparam logic [TMR_W-1:0] FLUSH_TERM = TMR_W'(FLUSH_CYC - 1);
    localparam logic [TMR_W-1:0] PIX_TERM   = TMR_W'(IMG_PIXELS - 1);
    localparam logic [TMR_W-1:0] TO_TERM    = TMR_W'(TIMEOUT_CYC - 1);

    seq_state_e state_q, state_d;

    logic       started_q, started_d;
    logic       pix_ready_q, pix_ready_d;
    logic       cnn_rst_n_q, cnn_rst_n_d;
    logic [7:0] data_q, data_d;
    logic       res_valid_q, res_valid_d;
    logic [3:0] res_class_q, res_class_d;
    logic [1:0] res_err_q, res_err_d;
    logic       busy_q, busy_d;

    logic             accept;
    logic             tmr_load;
    logic             tmr_inc;
    logic             tmr_term;
    logic [TMR_W-1:0] tmr_term_val;

    assign accept = pix_valid && pix_ready_q;

    // Terminal value depends only on the current state, keeping the timer
    // compare out of the next-state process.
    assign tmr_term_val = (state_q == ST_FLUSH)  ? FLUSH_TERM :
                          (state_q == ST_STREAM) ? PIX_TERM   :
                          (state_q == ST_WAIT)   ? TO_TERM    : '1;

    cnn_seq_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i ('0),
        .inc_i      (tmr_inc),
        .term_val_i (tmr_term_val),
        .term_o     (tmr_term)
    );

    always_comb begin
        state_d     = state_q;
        started_d   = started_q;
        data_d      = '0;
        res_class_d = res_class_q;
        res_err_d   = res_err_q;
        tmr_load    = 1'b0;
        tmr_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                started_d = 1'b0;
                if (start) begin
                    state_d  = ST_FLUSH;
                    tmr_load = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (tmr_term) begin
                    state_d  = ST_STREAM;
                    tmr_load = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    data_d    = pix_data;
                    started_d = 1'b1;
                    if (tmr_term) begin
                        state_d  = ST_WAIT;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end else if (started_q) begin
                    // Host stalled mid-frame: the datapath cannot be paused.
                    state_d     = ST_RESULT;
                    res_class_d = ERR_CLASS;
                    res_err_d   = ERR_UNDERRUN;
                end
            end
            ST_WAIT: begin
                // A decision in the terminal cycle still counts.
                if (cnn_valid) begin
                    state_d     = ST_RESULT;
                    res_class_d = cnn_decision;
                    res_err_d   = ERR_OK;
                end else if (tmr_term) begin
                    state_d     = ST_RESULT;
                    res_class_d = ERR_CLASS;
                    res_err_d   = ERR_TIMEOUT;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_RESULT: begin
                if (res_valid_q && res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they follow the next state.
        pix_ready_d = (state_d == ST_STREAM);
        res_valid_d = (state_d == ST_RESULT);
        busy_d      = (state_d != ST_IDLE);
        cnn_rst_n_d = (state_d == ST_WAIT) || (state_d == ST_RESULT) ||
                      ((state_d == ST_STREAM) && started_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            started_q   <= 1'b0;
            pix_ready_q <= 1'b0;
            cnn_rst_n_q <= 1'b0;
            data_q      <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_err_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            pix_ready_q <= pix_ready_d;
            cnn_rst_n_q <= cnn_rst_n_d;
            data_q      <= data_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
        end
    end

    assign pix_ready    = pix_ready_q;
    assign cnn_rst_n    = cnn_rst_n_q;
    assign cnn_data_out = data_q;
    assign res_valid    = res_valid_q;
    assign res_class    = res_class_q;
    assign res_err      = res_err_q;
    assign busy         = busy_q;

`ifdef CNN_SEQ_PERF_EN
    logic [15:0] lat_q, lat_d;

    // Counts edges after the first accept up to and including RESULT entry.
    always_comb begin
        lat_d = lat_q;
        if ((state_q == ST_IDLE) && start) begin
            lat_d = '0;
        end else if (started_q && ((state_q == ST_STREAM) || (state_q == ST_WAIT))) begin
            if (lat_q != 16'hFFFF) begin
                lat_d = lat_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end

    assign lat_cycles = lat_q;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cnn_frame_sequencer
// Frames are described by small plans (gaps, underrun point, abort point,
// decision timing, result back-pressure). Each plan is expanded into a table
// of per-cycle records {inputs, expected outputs} from the frame timeline,
// then the whole table is applied and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_cnn_frame_sequencer;

    localparam int IMG = 16;
    localparam int FL  = 2;
    localparam int TO  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       cnn_rst_n;
    logic [7:0] cnn_data_out;
    logic       cnn_valid;
    logic [3:0] cnn_decision;
    logic       res_valid;
    logic [3:0] res_class;
    logic [1:0] res_err;
    logic       res_ready;
    logic       busy;
`ifdef CNN_SEQ_PERF_EN
    logic [15:0] lat_cycles;
`endif

    always #5 clk = ~clk;

    cnn_frame_sequencer #(
        .IMG_PIXELS  (IMG),
        .FLUSH_CYC   (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .cnn_rst_n    (cnn_rst_n),
        .cnn_data_out (cnn_data_out),
        .cnn_valid    (cnn_valid),
        .cnn_decision (cnn_decision),
        .res_valid    (res_valid),
        .res_class    (res_class),
        .res_err      (res_err),
        .res_ready    (res_ready),
        .busy         (busy)
`ifdef CNN_SEQ_PERF_EN
        ,
        .lat_cycles   (lat_cycles)
`endif
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       pix_valid;
        logic [7:0] pix_data;
        logic       cnn_valid;
        logic [3:0] cnn_decision;
        logic       res_ready;
        logic       e_pix_ready;
        logic       e_cnn_rst_n;
        logic [7:0] e_data;
        logic       e_res_valid;
        logic       e_busy;
        logic       chk_res;
        logic [3:0] e_class;
        logic [1:0] e_err;
        int         e_lat;
        int         frame;
    } cyc_t;

    typedef struct {
        int         i0;          // idle cycles before start
        int         d0;          // pix_valid-low cycles before first pixel
        int         under_k;     // >0: pix_valid drops after this many pixels
        int         abort_k;     // >0: rst after this many pixels
        int         wait_j;      // WAIT cycle carrying cnn_valid, -1 = never
        logic [3:0] dec;
        int         r;           // cycles res_ready held low
        bit         seq_data;    // pixels 1..N instead of random
        bit         start_noise; // hold start high during RESULT
    } plan_t;

    cyc_t  vec[$];
    plan_t plans[$];
    int    fid;
    int    n_chk;
    int    n_err;

    function automatic cyc_t noise();
        cyc_t c;
        c.rst          = 1'b0;
        c.start        = 1'b0;
        c.pix_valid    = 1'($urandom_range(0, 1));
        c.pix_data     = 8'($urandom);
        c.cnn_valid    = 1'($urandom_range(0, 1));
        c.cnn_decision = 4'($urandom);
        c.res_ready    = 1'($urandom_range(0, 1));
        c.e_pix_ready  = 1'b0;
        c.e_cnn_rst_n  = 1'b0;
        c.e_data       = 8'd0;
        c.e_res_valid  = 1'b0;
        c.e_busy       = 1'b0;
        c.chk_res      = 1'b0;
        c.e_class      = 4'd0;
        c.e_err        = 2'd0;
        c.e_lat        = 0;
        c.frame        = fid;
        return c;
    endfunction

    function automatic plan_t mkplan(int i0, int d0, int uk, int ak, int wj,
                                     logic [3:0] dec, int r, bit sq, bit sn);
        plan_t p;
        p.i0 = i0; p.d0 = d0; p.under_k = uk; p.abort_k = ak; p.wait_j = wj;
        p.dec = dec; p.r = r; p.seq_data = sq; p.start_noise = sn;
        return p;
    endfunction

    task automatic build(input plan_t p);
        cyc_t c;
        int   m;
        int   first_idx;
        int   lat;
        logic [3:0] cls;
        logic [1:0] err;
        bit   done;
        fid++;
        first_idx = 0;
        for (int i = 0; i < p.i0; i++) begin
            c = noise();
            vec.push_back(c);
        end
        c = noise(); c.start = 1'b1; c.e_busy = 1'b1;
        vec.push_back(c);
        for (int i = 1; i < FL; i++) begin
            c = noise(); c.start = 1'($urandom_range(0, 1)); c.e_busy = 1'b1;
            vec.push_back(c);
        end
        // Last flush edge: pix_ready is still low, so pix_valid noise is ignored.
        c = noise(); c.start = 1'($urandom_range(0, 1));
        c.e_pix_ready = 1'b1; c.e_busy = 1'b1;
        vec.push_back(c);
        for (int i = 0; i < p.d0; i++) begin
            c = noise(); c.pix_valid = 1'b0; c.start = 1'($urandom_range(0, 1));
            c.e_pix_ready = 1'b1; c.e_busy = 1'b1;
            vec.push_back(c);
        end
        m = (p.under_k > 0) ? p.under_k : ((p.abort_k > 0) ? p.abort_k : IMG);
        for (int i = 0; i < m; i++) begin
            c = noise(); c.pix_valid = 1'b1; c.start = 1'($urandom_range(0, 1));
            if (p.seq_data) c.pix_data = 8'(i + 1);
            c.e_data = c.pix_data; c.e_cnn_rst_n = 1'b1; c.e_busy = 1'b1;
            c.e_pix_ready = (i != IMG - 1);
            if (i == 0) first_idx = vec.size();
            vec.push_back(c);
        end
        if (p.abort_k > 0) begin
            c = noise(); c.rst = 1'b1; c.start = 1'($urandom_range(0, 1));
            c.chk_res = 1'b1;
            vec.push_back(c);
            return;
        end
        cls = 4'd0; err = 2'd0;
        if (p.under_k > 0) begin
            c = noise(); c.pix_valid = 1'b0;
            cls = 4'hF; err = 2'd1;
        end else begin
            done = 1'b0;
            for (int j = 0; !done; j++) begin
                c = noise(); c.cnn_valid = (j == p.wait_j);
                c.start = 1'($urandom_range(0, 1));
                if (j == p.wait_j) begin
                    c.cnn_decision = p.dec; cls = p.dec; err = 2'd0; done = 1'b1;
                end else if (j == TO - 1) begin
                    cls = 4'hF; err = 2'd2; done = 1'b1;
                end else begin
                    c.e_cnn_rst_n = 1'b1; c.e_busy = 1'b1;
                    vec.push_back(c);
                end
            end
        end
        lat = vec.size() - first_idx;
        c.e_res_valid = 1'b1; c.e_cnn_rst_n = 1'b1; c.e_busy = 1'b1;
        c.chk_res = 1'b1; c.e_class = cls; c.e_err = err; c.e_lat = lat;
        vec.push_back(c);
        for (int h = 0; h < p.r; h++) begin
            c = noise(); c.res_ready = 1'b0;
            c.start = p.start_noise ? 1'b1 : 1'($urandom_range(0, 1));
            c.e_res_valid = 1'b1; c.e_cnn_rst_n = 1'b1; c.e_busy = 1'b1;
            c.chk_res = 1'b1; c.e_class = cls; c.e_err = err; c.e_lat = lat;
            vec.push_back(c);
        end
        c = noise(); c.res_ready = 1'b1; c.start = 1'($urandom_range(0, 1));
        vec.push_back(c);
    endtask

    task automatic chk(input string nm, input int fr, input int cy,
                       input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s frame=%0d cycle=%0d actual=%0h expected=%0h",
                     nm, fr, cy, act, exp);
        end
    endtask

    initial begin
        cyc_t c;
        int   sel;
        plan_t p;
        n_chk = 0; n_err = 0; fid = 0;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0;
        cnn_valid = 1'b0; cnn_decision = 4'd0; res_ready = 1'b0;

        plans.push_back(mkplan(1, 0, 0, 0,  9, 4'd7, 0, 1, 0));  // contiguous frame, class 7
        plans.push_back(mkplan(0, 5, 0, 0,  3, 4'd3, 1, 1, 0));  // late first pixel
        plans.push_back(mkplan(2, 0, 6, 0, -1, 4'd0, 2, 1, 0));  // underrun after pixel 6
        plans.push_back(mkplan(0, 1, 0, 0, -1, 4'd0, 0, 1, 0));  // timeout
        plans.push_back(mkplan(1, 0, 0, 0, 31, 4'hA, 0, 0, 0));  // decision on last WAIT cycle
        plans.push_back(mkplan(0, 0, 0, 0, 30, 4'h4, 0, 0, 0));
        plans.push_back(mkplan(0, 2, 0, 0,  0, 4'd5, 10, 0, 1)); // back-pressure, start ignored
        plans.push_back(mkplan(1, 0, 15, 0, -1, 4'd0, 0, 0, 0)); // underrun on last pixel
        plans.push_back(mkplan(0, 0, 0, 8, -1, 4'd0, 0, 1, 0));  // rst at pixel 8
        plans.push_back(mkplan(1, 0, 0, 0,  5, 4'd2, 0, 1, 0));  // clean frame after abort
        for (int f = 0; f < 24; f++) begin
            sel = $urandom_range(0, 9);
            p = mkplan($urandom_range(0, 3), $urandom_range(0, 4), 0, 0,
                       ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, TO - 1),
                       4'($urandom), $urandom_range(0, 4), 0, 0);
            if (sel inside {6, 7}) p.under_k = $urandom_range(1, IMG - 1);
            if (sel == 8) p.abort_k = $urandom_range(1, IMG - 1);
            plans.push_back(p);
        end

        c = noise(); c.rst = 1'b1; c.chk_res = 1'b1;
        vec.push_back(c);
        foreach (plans[k]) build(plans[k]);

        for (int i = 0; i < vec.size(); i++) begin
            c = vec[i];
            rst = c.rst; start = c.start; pix_valid = c.pix_valid;
            pix_data = c.pix_data; cnn_valid = c.cnn_valid;
            cnn_decision = c.cnn_decision; res_ready = c.res_ready;
            @(posedge clk);
            #1;
            chk("pix_ready", c.frame, i, 16'(pix_ready), 16'(c.e_pix_ready));
            chk("cnn_rst_n", c.frame, i, 16'(cnn_rst_n), 16'(c.e_cnn_rst_n));
            chk("cnn_data_out", c.frame, i, 16'(cnn_data_out), 16'(c.e_data));
            chk("res_valid", c.frame, i, 16'(res_valid), 16'(c.e_res_valid));
            chk("busy", c.frame, i, 16'(busy), 16'(c.e_busy));
            if (c.chk_res) begin
                chk("res_class", c.frame, i, 16'(res_class), 16'(c.e_class));
                chk("res_err", c.frame, i, 16'(res_err), 16'(c.e_err));
`ifdef CNN_SEQ_PERF_EN
                if (c.e_res_valid)
                    chk("lat_cycles", c.frame, i, lat_cycles, 16'(c.e_lat));
                else
                    chk("lat_cycles", c.frame, i, lat_cycles, 16'd0);
`endif
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cnn_frame_sequencer.md
CNN_FRAME_SEQUENCER -- requirements
Module: cnn_frame_sequencer

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 784, pixels per frame (28x28).
REQ-002 SHALL have parameter FLUSH_CYC, default 2, minimum datapath-reset cycles between frames.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, max cycles from last pixel to decision.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  frame request pulse.
- pix_valid  in  1  host pixel valid.
- pix_data  in  8  host pixel.
- pix_ready  out  1  sequencer accepts pixel.
- cnn_rst_n  out  1  active-low reset to CNN datapath.
- cnn_data_out  out  8  pixel stream to datapath data_in.
- cnn_valid  in  1  datapath decision valid.
- cnn_decision  in  4  datapath class.
- res_valid  out  1  result available.
- res_class  out  4  captured class; 4'hF on error.
- res_err  out  2  0 ok, 1 underrun, 2 timeout.
- res_ready  in  1  host consumes result.
- busy  out  1  state != IDLE.

Function
REQ-005 SHALL implement FSM IDLE, FLUSH, STREAM, WAIT, RESULT; all outputs registered.
REQ-006 IDLE: start=1 -> FLUSH next cycle; start in any other state ignored.
REQ-007 FLUSH: cnn_rst_n=0 for exactly FLUSH_CYC cycles, then STREAM.
REQ-008 STREAM: pix_ready=1; cnn_rst_n held 0 until first pixel accepted.
REQ-009 Accepted pixel (pix_valid&pix_ready) appears on cnn_data_out next cycle; cnn_rst_n rises in that same cycle.
REQ-010 After first accept, pix_valid=0 in any STREAM cycle -> underrun: res_err=1, res_class=4'hF, go RESULT, pix_ready=0 next cycle.
REQ-011 Pixel counter (11 bits, 0..IMG_PIXELS-1); on accept of pixel IMG_PIXELS-1 -> WAIT, pix_ready=0 next cycle.
REQ-012 cnn_data_out SHALL be 0 outside the cycle following an accept.
REQ-013 WAIT: timeout counter increments each cycle; cnn_valid=1 -> capture cnn_decision into res_class, res_err=0, go RESULT.
REQ-014 WAIT: counter reaching TIMEOUT_CYC-1 without cnn_valid -> res_err=2, res_class=4'hF, go RESULT.
REQ-015 cnn_valid and timeout in same cycle: cnn_valid wins.
REQ-016 cnn_valid outside WAIT SHALL be ignored.
REQ-017 RESULT: res_valid=1, res_class/res_err stable until res_valid&res_ready; then IDLE, res_valid=0 next cycle.
REQ-018 cnn_rst_n SHALL be 1 in WAIT and RESULT, 0 in IDLE (datapath parked).

Reset
REQ-019 rst=1 at any edge: state IDLE, counters 0, pix_ready=0, cnn_rst_n=0, cnn_data_out=0, res_valid=0, res_class=0, res_err=0, busy=0.
REQ-020 rst mid-frame SHALL abort without producing a result; accepted pixels are discarded.

Configuration
REQ-021 Macro CNN_SEQ_PERF_EN defined: add output lat_cycles[15:0], cycles from first accept to RESULT entry, saturating at 16'hFFFF, valid with res_valid, reset 0.
REQ-022 Macro undefined: no lat_cycles port, no counter logic.

Structure
REQ-023 Shared package cnn_pkg SHALL hold state enum, res_err codes (ERR_OK/ERR_UNDERRUN/ERR_TIMEOUT), ERR_CLASS=4'hF, IMG_PIXELS default.
REQ-024 One sub-module cnn_seq_timer (loadable up-counter with terminal flag) SHALL serve both pixel and timeout counts; FSM stays in top.

Verification
REQ-025 IMG_PIXELS=16: start, 16 contiguous pixels 1..16, cnn_valid with decision 7 at 10 cycles later -> cnn_data_out 1..16 on consecutive cycles, res_valid with class 7, err 0.
REQ-026 pix_valid low 5 cycles after FLUSH, then 16 pixels -> cnn_rst_n stays 0 those 5 cycles, rises with first cnn_data_out; normal result.
REQ-027 pix_valid drops after pixel 6 -> res_err=1, res_class=4'hF, pix_ready 0 next cycle.
REQ-028 TIMEOUT_CYC=32, no cnn_valid -> RESULT after 32 WAIT cycles, err 2; cnn_valid coincident with cycle 32 -> class captured, err 0.
REQ-029 res_ready held 0 for 10 cycles -> res_valid/res_class stable; start during RESULT ignored.
REQ-030 rst at pixel 8 -> all outputs at reset values next cycle; following start runs a clean frame.
